axis_stream_checker: RTL and testbench

//  AXI4-Stream sink placed directly downstream of the generator+FIFO pair; consumes its m00 stream.

---
 rtl/axis_stream_checker.sv | 118 +++++++++++
 tb/tb_axis_stream_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_checker.sv
// Purpose     : AXI4-Stream sink that checks generator packets (incrementing data, full tstrb,
//               PKT_LEN beats ending in tlast) and reports per-packet verdict/sum/length plus counters.
// Latency     : tlast accepted at edge N -> pkt_done and result fields valid after edge N+1.
// Backpressure: tready = enable while receiving; forced low for the single report cycle and in idle.
// Ports:
//   s00_axis_aclk / s00_axis_aresetn : clock, async active-low reset
//   enable                           : 1 = accept beats, 0 = pause (tready low)
//   s00_axis_t*                      : AXI4-Stream slave (tdata, tstrb, tvalid, tlast, tready)
//   pkt_done                         : 1-cycle pulse when pkt_ok/pkt_sum/pkt_len are updated
//   pkt_count / err_count            : packets completed (wraps) / bad packets (saturates)
module axis_stream_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    s00_axis_aclk,
    input  logic                    s00_axis_aresetn,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    output logic                    pkt_done,
    output logic                    pkt_ok,
    output logic [DATA_WIDTH-1:0]   pkt_sum,
    output logic [CNT_WIDTH-1:0]    pkt_len,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]    err_count
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] PKT_LEN_C = CNT_WIDTH'(PKT_LEN);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECV   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] expected;
    logic [DATA_WIDTH-1:0] sum_acc;
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic                  data_err;
    logic                  strb_err;
    logic                  beat;
    logic                  pkt_bad;

    // tready follows enable combinationally so a pause takes effect the same cycle.
    assign s00_axis_tready = (state == ST_RECV) && enable;
    assign beat            = s00_axis_tvalid && s00_axis_tready;

    // Evaluated in REPORT, when beat_cnt already includes the tlast beat.
    assign pkt_bad = data_err || strb_err || (beat_cnt != PKT_LEN_C);

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state     <= ST_IDLE;
            expected  <= '0;
            sum_acc   <= '0;
            beat_cnt  <= '0;
            data_err  <= 1'b0;
            strb_err  <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_ok    <= 1'b0;
            pkt_sum   <= '0;
            pkt_len   <= '0;
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (beat) begin
                        sum_acc <= sum_acc + s00_axis_tdata;
                        if (beat_cnt != {CNT_WIDTH{1'b1}}) begin
                            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        end
                        if (s00_axis_tdata != expected) begin
                            data_err <= 1'b1;
                        end
                        if (s00_axis_tstrb != {STRB_W{1'b1}}) begin
                            strb_err <= 1'b1;
                        end
                        // Resync on the observed word so one corrupt beat spoils only its own packet.
                        expected <= s00_axis_tdata + DATA_WIDTH'(1);
                        if (s00_axis_tlast) begin
                            state <= ST_REPORT;
                        end
                    end
                end
                ST_REPORT: begin
                    pkt_done  <= 1'b1;
                    pkt_ok    <= !pkt_bad;
                    pkt_sum   <= sum_acc;
                    pkt_len   <= beat_cnt;
                    pkt_count <= pkt_count + CNT_WIDTH'(1);
                    if (pkt_bad && (err_count != {CNT_WIDTH{1'b1}})) begin
                        err_count <= err_count + CNT_WIDTH'(1);
                    end
                    sum_acc  <= '0;
                    beat_cnt <= '0;
                    data_err <= 1'b0;
                    strb_err <= 1'b0;
                    state    <= enable ? ST_RECV : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_stream_checker.sv
// Purpose     : Directed bench for axis_stream_checker with hand-computed packet results.
// Latency     : Results are checked on the negedge one cycle after the tlast beat's report cycle.
// Backpressure: Beats are held valid until tready is seen high; stalls are bounded.
module tb_axis_stream_checker;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        pkt_done;
    logic        pkt_ok;
    logic [31:0] pkt_sum;
    logic [15:0] pkt_len;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    int n_cmp = 0;
    int n_err = 0;

    axis_stream_checker #(
        .DATA_WIDTH(32),
        .PKT_LEN   (16),
        .CNT_WIDTH (16)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .enable          (enable),
        .s00_axis_tdata  (tdata),
        .s00_axis_tstrb  (tstrb),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tlast  (tlast),
        .s00_axis_tready (tready),
        .pkt_done        (pkt_done),
        .pkt_ok          (pkt_ok),
        .pkt_sum         (pkt_sum),
        .pkt_len         (pkt_len),
        .pkt_count       (pkt_count),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        tvalid = 1'b0;
        tlast  = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called in the low clock phase; returns on the negedge after the beat was consumed.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l, input int gap);
        int guard;
        tvalid = 1'b0;
        repeat (gap) @(negedge clk);
        tvalid = 1'b1;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        guard  = 0;
        while (!tready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                n_cmp++;
                n_err++;
                $error("FAIL beat_timeout: observed=tready_low expected=tready_high");
                tvalid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] base, input int n, input int bad_i,
                            input logic [31:0] bad_v, input int strb_i);
        for (int i = 0; i < n; i++) begin
            send_beat((i == bad_i) ? bad_v : base + 32'(i),
                      (i == strb_i) ? 4'h7 : 4'hF, i == n - 1, 0);
        end
    endtask

    // Entered on the negedge right after the tlast beat was accepted.
    task automatic check_report(input string tag, input logic ok, input logic [31:0] sum,
                                input logic [15:0] len, input logic [15:0] cnt,
                                input logic [15:0] errc);
        chk({tag, "_rdy_rpt"}, tready, 0);
        chk({tag, "_done_early"}, pkt_done, 0);
        @(negedge clk);
        chk({tag, "_done"}, pkt_done, 1);
        chk({tag, "_ok"}, pkt_ok, ok);
        chk({tag, "_sum"}, pkt_sum, sum);
        chk({tag, "_len"}, pkt_len, len);
        chk({tag, "_count"}, pkt_count, cnt);
        chk({tag, "_errc"}, err_count, errc);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, tready, 0);
        chk({tag, "_done"}, pkt_done, 0);
        chk({tag, "_ok"}, pkt_ok, 0);
        chk({tag, "_sum"}, pkt_sum, 0);
        chk({tag, "_len"}, pkt_len, 0);
        chk({tag, "_count"}, pkt_count, 0);
        chk({tag, "_errc"}, err_count, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        enable = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        tstrb  = '0;
        tlast  = 1'b0;

        // 1: two clean packets back to back
        do_reset();
        chk_zero("t1_rst");
        enable = 1'b1;
        send_pkt(32'd0, 16, -1, 32'd0, -1);
        check_report("t1a", 1, 32'd120, 16, 1, 0);
        send_pkt(32'd16, 16, -1, 32'd0, -1);
        check_report("t1b", 1, 32'd376, 16, 2, 0);

        // 2: corrupt word in beat 5, then a clean packet (resync)
        do_reset();
        send_pkt(32'd0, 16, 5, 32'hDEAD, -1);
        check_report("t2a", 0, 32'd57120, 16, 1, 1);
        send_pkt(32'd16, 16, -1, 32'd0, -1);
        check_report("t2b", 1, 32'd376, 16, 2, 1);

        // 3: short packet then over-long packet
        do_reset();
        send_pkt(32'd0, 10, -1, 32'd0, -1);
        check_report("t3a", 0, 32'd45, 10, 1, 1);
        send_pkt(32'd10, 20, -1, 32'd0, -1);
        check_report("t3b", 0, 32'd390, 20, 2, 2);

        // 4: random valid gaps and a 7-cycle enable pause with tvalid held high
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                enable = 1'b0;
                tvalid = 1'b1;
                tdata  = 32'd8;
                tstrb  = 4'hF;
                tlast  = 1'b0;
                #1;
                for (int k = 0; k < 7; k++) begin
                    chk("t4_rdy_paused", tready, 0);
                    @(negedge clk);
                end
                enable = 1'b1;
                #1;
                chk("t4_rdy_resumed", tready, 1);
                send_beat(32'd8, 4'hF, 1'b0, 0);
            end else begin
                send_beat(32'(i), 4'hF, i == 15, int'($urandom_range(0, 2)));
            end
        end
        check_report("t4", 1, 32'd120, 16, 1, 0);
        chk("t4_rdy_after", tready, 1);

        // 5: bad strobe, then data wrapping through 0xFFFFFFFF -> 0
        do_reset();
        send_pkt(32'd0, 16, -1, 32'd0, 3);
        check_report("t5a", 0, 32'd120, 16, 1, 1);
        send_pkt(32'hFFFF_FFE8, 16, -1, 32'd0, -1);
        check_report("t5b", 0, 32'hFFFF_FEF8, 16, 2, 2);
        send_pkt(32'hFFFF_FFF8, 16, -1, 32'd0, -1);
        check_report("t5c", 1, 32'hFFFF_FFF8, 16, 3, 2);

        // 6: reset in the middle of a packet
        do_reset();
        send_pkt(32'd0, 16, -1, 32'd0, -1);
        check_report("t6a", 1, 32'd120, 16, 1, 0);
        for (int i = 16; i < 24; i++) begin
            send_beat(32'(i), 4'hF, 1'b0, 0);
        end
        rst_n = 1'b0;
        #1;
        chk_zero("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pkt(32'd0, 16, -1, 32'd0, -1);
        check_report("t6b", 1, 32'd120, 16, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
